// File: rtl/alu_mdu_pkg.sv
// Shared definitions for the ALU/MDU block: op encodings, FSM states and
// small op-decode helpers used by both the RTL and the testbench.
package alu_mdu_pkg;

    typedef enum logic [3:0] {
        ALU_OP_AND     = 4'd0,
        ALU_OP_OR      = 4'd1,
        ALU_OP_NOR     = 4'd2,
        ALU_OP_XOR     = 4'd3,
        ALU_OP_ADD     = 4'd4,
        ALU_OP_SUB     = 4'd5,
        ALU_OP_SUB_NOT = 4'd6,
        ALU_OP_SLT     = 4'd7,
        ALU_OP_SLTU    = 4'd8,
        ALU_OP_SLL     = 4'd9,
        ALU_OP_SRL     = 4'd10,
        ALU_OP_SRA     = 4'd11,
        ALU_OP_MULT    = 4'd12,
        ALU_OP_MULTU   = 4'd13,
        ALU_OP_DIV     = 4'd14,
        ALU_OP_DIVU    = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_e;

    // MULT/MULTU/DIV/DIVU all live in the top quarter of the op space.
    function automatic logic alu_op_is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

    // Within the multi-cycle group, bit 0 selects unsigned, bit 1 selects divide.
    function automatic logic alu_op_is_signed(input logic [3:0] op);
        return ~op[0];
    endfunction

    function automatic logic alu_op_is_div(input logic [3:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Request/response bundle between the EX-stage pipeline (master) and the ALU/MDU (slave).
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;

    modport master (
        output in_valid, op, a, b,
        input  in_ready, out_valid, result, zero, hi, lo, busy
    );

    modport slave (
        input  in_valid, op, a, b,
        output in_ready, out_valid, result, zero, hi, lo, busy
    );
endinterface

// File: rtl/alu_mdu_iter.sv
// Unsigned iteration datapath: shift-add multiply or restoring divide, one bit
// per cycle for WIDTH cycles. acc_hi/acc_lo hold product or remainder/quotient.
module alu_mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             last,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg, opb_reg;
    logic             is_div_reg;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [WIDTH:0]   div_shifted;
    logic [WIDTH+1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi, div_lo;
    logic [WIDTH-1:0] hi_next, lo_next;

    // Multiply: multiplier sits in lo and is consumed LSB first while the
    // partial product shifts in from the top.
    always_comb begin
        mul_sum = {1'b0, hi_reg} + ({(WIDTH+1){lo_reg[0]}} & {1'b0, opb_reg});
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end

    // Divide: dividend shifts out of lo into the remainder; quotient bits
    // shift into lo from the bottom. Extra diff bit keeps the sign unambiguous.
    always_comb begin
        div_shifted = {hi_reg, lo_reg[WIDTH-1]};
        div_diff    = {1'b0, div_shifted} - {2'b00, opb_reg};
        div_ge      = ~div_diff[WIDTH+1];
        div_hi      = div_ge ? div_diff[WIDTH-1:0] : div_shifted[WIDTH-1:0];
        div_lo      = {lo_reg[WIDTH-2:0], div_ge};
    end

    always_comb begin
        hi_next = is_div_reg ? div_hi : mul_hi;
        lo_next = is_div_reg ? div_lo : mul_lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            opb_reg    <= '0;
            is_div_reg <= 1'b0;
        end else if (start) begin
            count_reg  <= CW'(WIDTH);
            hi_reg     <= '0;
            lo_reg     <= op_a;
            opb_reg    <= op_b;
            is_div_reg <= is_div;
        end else if (count_reg != '0) begin
            count_reg  <= count_reg - CW'(1);
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
        end
    end

    assign last   = (count_reg == CW'(1));
    assign acc_hi = hi_reg;
    assign acc_lo = lo_reg;

endmodule

// File: rtl/alu_mdu.sv
// Registered EX-stage ALU with iterative multiply/divide into a HI/LO pair.
// Single-cycle ops return next cycle; MUL*/DIV* return WIDTH+2 cycles after accept.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mdu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    mdu_state_e state_reg, state_next;

    logic             busy;
    logic             accept;
    logic             start;
    logic             op_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    logic             sign_q_reg, sign_r_reg, b_zero_reg, is_div_reg;
    logic [WIDTH-1:0] a_orig_reg;

    logic             iter_last;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    logic [WIDTH-1:0] and_bits, or_bits, xor_bits;
    logic [WIDTH-1:0] add_sum, sub_diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    logic [2*WIDTH-1:0] product, product_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    logic             out_valid_reg, out_valid_next;
    logic             zero_reg, zero_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;

    assign busy   = (state_reg != ST_IDLE);
    assign accept = bus.in_valid & ~busy;
    assign start  = accept & alu_op_is_muldiv(bus.op);

    // Signed MDU ops iterate on magnitudes; signs are reapplied in FIX.
    assign op_signed = alu_op_is_signed(bus.op);
    assign a_neg     = op_signed & bus.a[WIDTH-1];
    assign b_neg     = op_signed & bus.b[WIDTH-1];
    assign a_mag     = a_neg ? -bus.a : bus.a;
    assign b_mag     = b_neg ? -bus.b : bus.b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            b_zero_reg <= 1'b0;
            is_div_reg <= 1'b0;
            a_orig_reg <= '0;
        end else if (start) begin
            sign_q_reg <= a_neg ^ b_neg;
            sign_r_reg <= a_neg;
            b_zero_reg <= (bus.b == '0);
            is_div_reg <= alu_op_is_div(bus.op);
            a_orig_reg <= bus.a;
        end
    end

    alu_mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .is_div (alu_op_is_div(bus.op)),
        .op_a   (a_mag),
        .op_b   (b_mag),
        .last   (iter_last),
        .acc_hi (iter_hi),
        .acc_lo (iter_lo)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = alu_op_is_div(bus.op) ? ST_DIV : ST_MUL;
            ST_MUL:  if (iter_last) state_next = ST_FIX;
            ST_DIV:  if (iter_last) state_next = ST_FIX;
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- single-cycle ALU ----------------
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic
        assign and_bits[gi] = bus.a[gi] & bus.b[gi];
        assign or_bits[gi]  = bus.a[gi] | bus.b[gi];
        assign xor_bits[gi] = bus.a[gi] ^ bus.b[gi];
    end

    assign add_sum  = bus.a + bus.b;
    assign sub_diff = bus.a - bus.b;
    assign shamt    = bus.b[SHW-1:0];

    always_comb begin
        alu_result = '0;
        case (bus.op)
            ALU_OP_AND:     alu_result = and_bits;
            ALU_OP_OR:      alu_result = or_bits;
            ALU_OP_NOR:     alu_result = ~or_bits;
            ALU_OP_XOR:     alu_result = xor_bits;
            ALU_OP_ADD:     alu_result = add_sum;
            ALU_OP_SUB:     alu_result = sub_diff;
            ALU_OP_SUB_NOT: alu_result = sub_diff;
            ALU_OP_SLT:     alu_result = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            ALU_OP_SLTU:    alu_result = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            ALU_OP_SLL:     alu_result = bus.a << shamt;
            ALU_OP_SRL:     alu_result = bus.a >> shamt;
            ALU_OP_SRA:     alu_result = $signed(bus.a) >>> shamt;
            default:        alu_result = '0;
        endcase
        alu_zero = (bus.op == ALU_OP_SUB_NOT) ? (alu_result != '0) : (alu_result == '0);
    end

    // ---------------- sign correction for MUL*/DIV* ----------------
    always_comb begin
        product     = {iter_hi, iter_lo};
        product_fix = sign_q_reg ? -product : product;
        fix_hi      = product_fix[2*WIDTH-1:WIDTH];
        fix_lo      = product_fix[WIDTH-1:0];
        if (is_div_reg) begin
            if (b_zero_reg) begin
                // Divide by zero: quotient saturates, remainder is the raw dividend.
                fix_lo = '1;
                fix_hi = a_orig_reg;
            end else begin
                fix_lo = sign_q_reg ? -iter_lo : iter_lo;
                fix_hi = sign_r_reg ? -iter_hi : iter_hi;
            end
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        out_valid_next = 1'b0;
        result_next    = result_reg;
        zero_next      = zero_reg;
        hi_next        = hi_reg;
        lo_next        = lo_reg;
        if (state_reg == ST_FIX) begin
            out_valid_next = 1'b1;
            hi_next        = fix_hi;
            lo_next        = fix_lo;
            result_next    = fix_lo;
            zero_next      = (fix_lo == '0);
        end else if (accept && !alu_op_is_muldiv(bus.op)) begin
            out_valid_next = 1'b1;
            result_next    = alu_result;
            zero_next      = alu_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            hi_reg        <= '0;
            lo_reg        <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            result_reg    <= result_next;
            zero_reg      <= zero_next;
            hi_reg        <= hi_next;
            lo_reg        <= lo_next;
        end
    end

    assign bus.busy      = busy;
    assign bus.in_ready  = ~busy;
    assign bus.out_valid = out_valid_reg;
    assign bus.result    = result_reg;
    assign bus.zero      = zero_reg;
    assign bus.hi        = hi_reg;
    assign bus.lo        = lo_reg;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed plus randomized ops checked
// against an arithmetic reference model of the ALU and HI/LO pair.
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_mdu_if #(.WIDTH(WIDTH)) bus ();

    alu_mdu #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] e_result;
    logic        e_zero;

    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e_result = '0;
        case (op)
            ALU_OP_AND:     e_result = a & b;
            ALU_OP_OR:      e_result = a | b;
            ALU_OP_NOR:     e_result = ~(a | b);
            ALU_OP_XOR:     e_result = a ^ b;
            ALU_OP_ADD:     e_result = a + b;
            ALU_OP_SUB:     e_result = a - b;
            ALU_OP_SUB_NOT: e_result = a - b;
            ALU_OP_SLT:     e_result = (sa < sb) ? 32'd1 : 32'd0;
            ALU_OP_SLTU:    e_result = (a < b) ? 32'd1 : 32'd0;
            ALU_OP_SLL:     e_result = a << b[4:0];
            ALU_OP_SRL:     e_result = a >> b[4:0];
            ALU_OP_SRA:     e_result = 32'(sa >>> b[4:0]);
            ALU_OP_MULT: begin
                p = 64'(sa * sb);
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            ALU_OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            ALU_OP_DIV, ALU_OP_DIVU: begin
                if (b == 0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a;
                end else begin
                    if (op == ALU_OP_DIV) begin
                        q = sa / sb; r = sa % sb;
                    end else begin
                        q = longint'({32'd0, a}) / longint'({32'd0, b});
                        r = longint'({32'd0, a}) % longint'({32'd0, b});
                    end
                    m_lo = q[31:0]; m_hi = r[31:0];
                end
            end
            default:        e_result = '0;
        endcase
        if (alu_op_is_muldiv(op)) begin
            e_result = m_lo;
            e_zero   = (m_lo == 0);
        end else begin
            e_zero = (op == ALU_OP_SUB_NOT) ? (e_result != 0) : (e_result == 0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.busy, bus.result, bus.zero, bus.hi, bus.lo} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ov=%b busy=%b res=%h z=%b hi=%h lo=%h want all 0",
                     bus.out_valid, bus.busy, bus.result, bus.zero, bus.hi, bus.lo);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  d_op[6] = '{ALU_OP_ADD, ALU_OP_SUB_NOT, ALU_OP_SLT, ALU_OP_SLTU, ALU_OP_SRA, ALU_OP_SLL};
        logic [31:0] d_a[6]  = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1};
        logic [31:0] d_b[6]  = '{32'd1, 32'd5, 32'd1, 32'd1, 32'h24, 32'd31};
        logic [31:0] d_r[6]  = '{32'h8000_0000, 32'd0, 32'd1, 32'd0, 32'hF800_0000, 32'h8000_0000};
        logic        d_z[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1; bus.op = d_op[i]; bus.a = d_a[i]; bus.b = d_b[i];
            @(posedge clk); #1;
            checks++;
            if ({bus.out_valid, bus.result, bus.zero, bus.in_ready} !== {1'b1, d_r[i], d_z[i], 1'b1}) begin
                errors++;
                $display("FAIL directed_op%0d: got ov=%b res=%h z=%b rdy=%b want ov=1 res=%h z=%b rdy=1",
                         i, bus.out_valid, bus.result, bus.zero, bus.in_ready, d_r[i], d_z[i]);
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL directed_idle: got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_random_single();
        logic [3:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 11));
            a  = $urandom;
            b  = ($urandom % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom % 5 == 0) b = a;
            model(op, a, b);
            bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
            @(posedge clk); #1;
            checks++;
            if ({bus.out_valid, bus.result, bus.zero, bus.hi, bus.lo} !== {1'b1, e_result, e_zero, m_hi, m_lo}) begin
                errors++;
                $display("FAIL rand_single op=%0d a=%h b=%h: got ov=%b res=%h z=%b hi=%h lo=%h want res=%h z=%b hi=%h lo=%h",
                         op, a, b, bus.out_valid, bus.result, bus.zero, bus.hi, bus.lo, e_result, e_zero, m_hi, m_lo);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_muldiv();
        logic [3:0]  d_op[7] = '{ALU_OP_MULT, ALU_OP_MULTU, ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_DIV, ALU_OP_DIV, ALU_OP_MULT};
        logic [31:0] d_a[7]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFF9, 32'd0};
        logic [31:0] d_b[7]  = '{32'd3, 32'd3, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd9};
        logic [31:0] d_hi[7] = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd7, 32'd0, 32'hFFFF_FFF9, 32'd0};
        logic [31:0] d_lo[7] = '{32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        logic [3:0]  op;
        logic [31:0] a, b, x_hi, x_lo;
        int cyc, low;
        for (int i = 0; i < 17; i++) begin
            if (i < 7) begin
                op = d_op[i]; a = d_a[i]; b = d_b[i];
            end else begin
                op = 4'($urandom_range(12, 15));
                a  = $urandom;
                case ($urandom % 4)
                    0:       b = 32'd0;
                    1:       b = 32'($urandom_range(1, 15));
                    2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                    default: b = $urandom;
                endcase
            end
            model(op, a, b);
            x_hi = (i < 7) ? d_hi[i] : m_hi;
            x_lo = (i < 7) ? d_lo[i] : m_lo;
            bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            cyc = 1; low = 0;
            while (bus.out_valid !== 1'b1 && cyc < 100) begin
                if (bus.in_ready === 1'b0) low++;
                @(posedge clk); #1;
                cyc++;
            end
            checks++;
            if (cyc != WIDTH + 2 || low != WIDTH + 1) begin
                errors++;
                $display("FAIL muldiv_latency op=%0d: got out_valid at cycle %0d, in_ready low %0d cycles; want %0d and %0d",
                         op, cyc, low, WIDTH + 2, WIDTH + 1);
            end
            checks++;
            if ({bus.hi, bus.lo, bus.result, bus.zero, bus.in_ready} !== {x_hi, x_lo, x_lo, x_lo == 0, 1'b1}) begin
                errors++;
                $display("FAIL muldiv_value op=%0d a=%h b=%h: got hi=%h lo=%h res=%h z=%b rdy=%b want hi=%h lo=%h",
                         op, a, b, bus.hi, bus.lo, bus.result, bus.zero, bus.in_ready, x_hi, x_lo);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL muldiv_pulse op=%0d: got out_valid=%b want 0", op, bus.out_valid);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] xa, xb;
        int cyc;
        xa = $urandom; xb = $urandom;
        model(ALU_OP_MULT, 32'hFFFF_FFFE, 32'd3);
        bus.in_valid = 1'b1; bus.op = ALU_OP_MULT; bus.a = 32'hFFFF_FFFE; bus.b = 32'd3;
        @(posedge clk); #1;
        bus.op = ALU_OP_ADD; bus.a = xa; bus.b = xb;
        cyc = 1;
        while (bus.out_valid !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc != WIDTH + 2 || bus.hi !== m_hi || bus.lo !== m_lo) begin
            errors++;
            $display("FAIL busy_ignore_mul: got cycle %0d hi=%h lo=%h want cycle %0d hi=%h lo=%h",
                     cyc, bus.hi, bus.lo, WIDTH + 2, m_hi, m_lo);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.result, bus.hi, bus.lo} !== {1'b1, xa + xb, m_hi, m_lo}) begin
            errors++;
            $display("FAIL busy_ignore_add: got ov=%b res=%h hi=%h lo=%h want ov=1 res=%h hi=%h lo=%h",
                     bus.out_valid, bus.result, bus.hi, bus.lo, xa + xb, m_hi, m_lo);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        int stray;
        logic [31:0] xa, xb;
        bus.in_valid = 1'b1; bus.op = ALU_OP_DIV; bus.a = 32'hFFFF_FFF9; bus.b = 32'd2;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midop_busy: got busy=%b want 1", bus.busy);
        end
        rst_n = 1'b0;
        m_hi = '0; m_lo = '0;
        #1;
        checks++;
        if ({bus.out_valid, bus.busy, bus.hi, bus.lo, bus.result, bus.zero} !== '0) begin
            errors++;
            $display("FAIL midop_reset: got ov=%b busy=%b hi=%h lo=%h res=%h z=%b want all 0",
                     bus.out_valid, bus.busy, bus.hi, bus.lo, bus.result, bus.zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL midop_stray: got %0d cycles with out_valid/busy after reset want 0", stray);
        end
        xa = $urandom; xb = $urandom;
        model(ALU_OP_ADD, xa, xb);
        bus.in_valid = 1'b1; bus.op = ALU_OP_ADD; bus.a = xa; bus.b = xb;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.result, bus.zero, bus.hi, bus.lo} !== {1'b1, e_result, e_zero, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL midop_add: got ov=%b res=%h z=%b hi=%h lo=%h want ov=1 res=%h z=%b hi=0 lo=0",
                     bus.out_valid, bus.result, bus.zero, bus.hi, bus.lo, e_result, e_zero);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.op       = '0;
        bus.a        = '0;
        bus.b        = '0;
        test_reset();
        test_back_to_back();
        test_random_single();
        test_muldiv();
        test_busy_ignore();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
